// File: rtl/quat_keyframe_driver.sv
// Keyframe sequencer for the NLERP stage: pairs consecutive quaternion keyframes,
// corrects the second onto the short arc and emits 2^STEPS_LOG2 weighted samples per pair.
module quat_keyframe_driver #(
    parameter int W          = 32,
    parameter int STEPS_LOG2 = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         kf_valid,
    output logic         kf_ready,
    input  logic [W-1:0] kf_w,
    input  logic [W-1:0] kf_x,
    input  logic [W-1:0] kf_y,
    input  logic [W-1:0] kf_z,
    input  logic         kf_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] q0_w,
    output logic [W-1:0] q0_x,
    output logic [W-1:0] q0_y,
    output logic [W-1:0] q0_z,
    output logic [W-1:0] q1_w,
    output logic [W-1:0] q1_x,
    output logic [W-1:0] q1_y,
    output logic [W-1:0] q1_z,
    output logic [31:0]  alpha,
    output logic         out_last
);
    localparam int KW = STEPS_LOG2 + 1;
    localparam logic [KW-1:0] K_LAST = KW'((64'd1 << STEPS_LOG2) - 64'd1);

    typedef enum logic [2:0] {EMPTY, WAIT_NEXT, DOT, EMIT, FINAL} state_t;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and outputs hold while valid && !ready.
    state_t                state, state_n;
    logic signed [W-1:0]   q0_r [4];
    logic signed [W-1:0]   q1_r [4];
    logic signed [W-1:0]   kf_q [4];
    logic [KW-1:0]         k;
    logic [1:0]            idx;
    logic signed [2*W+1:0] acc, acc_n;
    logic signed [2*W-1:0] prod;
    logic                  last_r;
    logic                  kf_fire, out_fire, flip;

    function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] v);
        if (v == {1'b1, {(W-1){1'b0}}})
            return {1'b0, {(W-1){1'b1}}};
        return -v;
    endfunction

    assign kf_q[0]   = kf_w;
    assign kf_q[1]   = kf_x;
    assign kf_q[2]   = kf_y;
    assign kf_q[3]   = kf_z;

    assign kf_ready  = !rst && (state == EMPTY || state == WAIT_NEXT);
    assign out_valid = (state == EMIT) || (state == FINAL);
    assign kf_fire   = kf_valid && kf_ready;
    assign out_fire  = out_valid && out_ready;

    // One component product per DOT cycle; the sign of the full sum decides the flip.
    assign prod  = $signed((2*W)'(q0_r[idx])) * $signed((2*W)'(q1_r[idx]));
    assign acc_n = acc + (2*W+2)'(prod);
    assign flip  = (idx == 2'd3) && acc_n[2*W+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        alpha    = '0;
        out_last = 1'b0;
        case (state)
            EMPTY:     if (kf_fire) state_n = kf_last ? FINAL : WAIT_NEXT;
            WAIT_NEXT: if (kf_fire) state_n = DOT;
            DOT:       if (idx == 2'd3) state_n = EMIT;
            EMIT: begin
                alpha = 32'(k) << (30 - STEPS_LOG2);
                if (out_fire && k == K_LAST) state_n = last_r ? FINAL : WAIT_NEXT;
            end
            FINAL: begin
                alpha    = 32'h4000_0000;
                out_last = 1'b1;
                if (out_fire) state_n = EMPTY;
            end
            default:   state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                q0_r[i] <= '0;
                q1_r[i] <= '0;
            end
            k      <= '0;
            idx    <= '0;
            acc    <= '0;
            last_r <= 1'b0;
        end else begin
            case (state)
                EMPTY: if (kf_fire) begin
                    for (int i = 0; i < 4; i++) begin
                        q0_r[i] <= kf_q[i];
                        if (kf_last) q1_r[i] <= kf_q[i];
                    end
                end
                WAIT_NEXT: if (kf_fire) begin
                    for (int i = 0; i < 4; i++) q1_r[i] <= kf_q[i];
                    last_r <= kf_last;
                    idx    <= '0;
                    acc    <= '0;
                end
                DOT: begin
                    acc <= acc_n;
                    idx <= idx + 2'd1;
                    k   <= '0;
                    if (flip)
                        for (int i = 0; i < 4; i++) q1_r[i] <= neg_sat(q1_r[i]);
                end
                EMIT: if (out_fire) begin
                    if (k == K_LAST) begin
                        k <= '0;
                        // Chain: this segment's corrected end becomes the next start.
                        if (!last_r)
                            for (int i = 0; i < 4; i++) q0_r[i] <= q1_r[i];
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                FINAL: if (out_fire) last_r <= 1'b0;
                default: ;
            endcase
        end
    end

    assign q0_w = q0_r[0];
    assign q0_x = q0_r[1];
    assign q0_y = q0_r[2];
    assign q0_z = q0_r[3];
    assign q1_w = q1_r[0];
    assign q1_x = q1_r[1];
    assign q1_y = q1_r[2];
    assign q1_z = q1_r[3];

endmodule

// File: tb/tb_quat_keyframe_driver.sv
// Bench for quat_keyframe_driver: directed table of keyframe pairs, hand-written
// stall/reset/single-keyframe sequences, and random paths against a path-level model.
module tb_quat_keyframe_driver;
  localparam int NSTEP = 4;

  typedef logic [3:0][31:0] quat_t;
  typedef struct packed { quat_t q; logic last; } kf_t;
  typedef struct packed { quat_t q0; quat_t q1; logic [31:0] alpha; logic last; } samp_t;
  typedef struct { quat_t a; quat_t b; quat_t fx; } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        kf_valid = 1'b0;
  logic        kf_ready;
  logic [31:0] kf_w = '0, kf_x = '0, kf_y = '0, kf_z = '0;
  logic        kf_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] q0_w, q0_x, q0_y, q0_z, q1_w, q1_x, q1_y, q1_z, alpha;
  logic        out_last;

  int    n_tests = 0;
  int    n_fail = 0;
  int    n_samples = 0;
  int    cyc = 0;
  int    acc_cyc = 0;
  bit    rand_bp = 1'b0;
  samp_t exp_q[$];
  kf_t   path[$];
  vec_t  vecs[5];
  samp_t mon_act, mon_exp;

  quat_keyframe_driver #(.W(32), .STEPS_LOG2(2)) dut (
    .clk(clk), .rst(rst), .kf_valid(kf_valid), .kf_ready(kf_ready),
    .kf_w(kf_w), .kf_x(kf_x), .kf_y(kf_y), .kf_z(kf_z), .kf_last(kf_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .q0_w(q0_w), .q0_x(q0_x), .q0_y(q0_y), .q0_z(q0_z),
    .q1_w(q1_w), .q1_x(q1_x), .q1_y(q1_y), .q1_z(q1_z),
    .alpha(alpha), .out_last(out_last)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic quat_t mk(input logic [31:0] w, x, y, z);
    quat_t q;
    q[0] = w; q[1] = x; q[2] = y; q[3] = z;
    return q;
  endfunction

  function automatic samp_t cur_out();
    samp_t s;
    s.q0 = mk(q0_w, q0_x, q0_y, q0_z);
    s.q1 = mk(q1_w, q1_x, q1_y, q1_z);
    s.alpha = alpha;
    s.last = out_last;
    return s;
  endfunction

  task automatic check(input string name, input logic [288:0] act, input logic [288:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // reference model: whole path -> list of samples
  task automatic model_path();
    samp_t s;
    quat_t cur0, q1;
    logic signed [127:0] d;
    int n;
    n = path.size();
    if (n == 1) begin
      s.q0 = path[0].q; s.q1 = path[0].q; s.alpha = 32'h4000_0000; s.last = 1'b1;
      exp_q.push_back(s);
      return;
    end
    cur0 = path[0].q;
    for (int i = 1; i < n; i++) begin
      q1 = path[i].q;
      d = 0;
      for (int c = 0; c < 4; c++) d += longint'($signed(cur0[c])) * longint'($signed(q1[c]));
      if (d < 0)
        for (int c = 0; c < 4; c++) q1[c] = (q1[c] == 32'h8000_0000) ? 32'h7FFF_FFFF : -q1[c];
      for (int j = 0; j < NSTEP; j++) begin
        s.q0 = cur0; s.q1 = q1; s.alpha = 32'(j * (32'h4000_0000 / NSTEP)); s.last = 1'b0;
        exp_q.push_back(s);
      end
      if (i == n - 1) begin
        s.q0 = cur0; s.q1 = q1; s.alpha = 32'h4000_0000; s.last = 1'b1;
        exp_q.push_back(s);
      end
      cur0 = q1;
    end
  endtask

  // driver: present one keyframe (call at posedge+#1), returns at posedge+#1 after accept
  task automatic send_kf(input kf_t k);
    int g;
    kf_w = k.q[0]; kf_x = k.q[1]; kf_y = k.q[2]; kf_z = k.q[3]; kf_last = k.last;
    kf_valid = 1'b1;
    g = 0;
    forever begin
      @(negedge clk);
      if (kf_ready) break;
      g++;
      if (g > 300) begin
        check("kf_accept_timeout", 1'b0, 1'b1);
        break;
      end
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    kf_valid = 1'b0;
    kf_last = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 1000) begin
      @(posedge clk); #1;
      g++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 289'(exp_q.size()), 289'(0));
      exp_q.delete();
    end
  endtask

  task automatic run_path();
    model_path();
    foreach (path[i]) send_kf(path[i]);
    wait_drain();
  endtask

  function automatic logic [31:0] rnd_comp();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  // scoreboard: every output handshake is compared with the head of exp_q
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_samples++;
      mon_act = cur_out();
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_sample: got %h required none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sample", mon_act, mon_exp);
      end
    end
  end

  // random backpressure
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    kf_t   k;
    samp_t s, snap;
    int    g, ns0;

    vecs[0] = '{mk(32'h4000_0000, 0, 0, 0), mk(0, 32'h4000_0000, 0, 0), mk(0, 32'h4000_0000, 0, 0)};
    vecs[1] = '{mk(32'h4000_0000, 0, 0, 0), mk(32'hC000_0000, 0, 0, 0), mk(32'h4000_0000, 0, 0, 0)};
    vecs[2] = '{mk(32'h4000_0000, 0, 0, 0), mk(32'hC000_0000, 32'h8000_0000, 0, 0),
                mk(32'h4000_0000, 32'h7FFF_FFFF, 0, 0)};
    vecs[3] = '{mk(0, 0, 32'h4000_0000, 0), mk(0, 0, 0, 32'hC000_0000), mk(0, 0, 0, 32'hC000_0000)};
    vecs[4] = '{mk(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000),
                mk(32'hF000_0000, 32'hF000_0000, 32'h1000_0000, 32'hE000_0000),
                mk(32'h1000_0000, 32'h1000_0000, 32'hF000_0000, 32'h2000_0000)};

    // reset state
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_kf_ready", kf_ready, 1'b0);
    check("rst_outputs", cur_out(), '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", kf_ready, 1'b1);
    @(posedge clk); #1;

    // directed pairs: alpha ramp, flip, saturation, orthogonal, multi-component flip
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < NSTEP; j++) begin
        s.q0 = vecs[i].a; s.q1 = vecs[i].fx; s.alpha = 32'(j) << 28; s.last = 1'b0;
        exp_q.push_back(s);
      end
      s.alpha = 32'h4000_0000; s.last = 1'b1;
      exp_q.push_back(s);
      k.q = vecs[i].a; k.last = 1'b0; send_kf(k);
      k.q = vecs[i].b; k.last = 1'b1; send_kf(k);
      if (i == 1) begin
        g = 0;
        while (g < 20) begin
          @(negedge clk);
          if (out_valid) break;
          g++;
        end
        check("first_sample_latency", 289'(cyc - acc_cyc), 289'(5));
      end
      wait_drain();
    end

    // single keyframe path
    path.delete();
    path.push_back('{mk(0, 0, 32'h4000_0000, 0), 1'b1});
    ns0 = n_samples;
    run_path();
    check("single_kf_count", 289'(n_samples - ns0), 289'(1));
    check("single_kf_ready", kf_ready, 1'b1);
    check("single_kf_idle", out_valid, 1'b0);

    // chaining with a 5-cycle stall at k=1
    path.delete();
    path.push_back('{mk(32'h4000_0000, 0, 0, 0), 1'b0});
    path.push_back('{mk(32'hC000_0000, 32'h1000_0000, 0, 0), 1'b0});
    path.push_back('{mk(0, 32'h4000_0000, 0, 0), 1'b1});
    model_path();
    ns0 = n_samples;
    out_ready = 1'b0;
    fork
      begin
        foreach (path[i]) send_kf(path[i]);
      end
      begin
        g = 0;
        while (!out_valid && g < 200) begin
          @(negedge clk);
          g++;
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        snap = cur_out();
        check("stall_alpha_k1", snap.alpha, 32'h1000_0000);
        repeat (5) begin
          @(negedge clk);
          check("stall_valid", out_valid, 1'b1);
          check("stall_hold", cur_out(), snap);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    check("chain_sample_count", 289'(n_samples - ns0), 289'(2 * NSTEP + 1));

    // reset while emitting k=2
    path.delete();
    path.push_back('{mk(32'h4000_0000, 0, 0, 0), 1'b0});
    path.push_back('{mk(0, 0, 32'h4000_0000, 0), 1'b1});
    model_path();
    foreach (path[i]) send_kf(path[i]);
    g = 0;
    while (g < 100) begin
      @(posedge clk); #1;
      if (out_valid && alpha == 32'h2000_0000) break;
      g++;
    end
    check("reach_k2", alpha, 32'h2000_0000);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_ready", kf_ready, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_ready_after", kf_ready, 1'b1);
    repeat (10) begin
      @(negedge clk);
      check("no_stale_valid", out_valid, 1'b0);
    end
    @(posedge clk); #1;
    path.delete();
    path.push_back('{mk(0, 32'h4000_0000, 0, 0), 1'b0});
    path.push_back('{mk(32'h8000_0000, 32'hC000_0000, 32'h1234_5678, 0), 1'b1});
    run_path();

    // random paths with random backpressure
    rand_bp = 1'b1;
    for (int p = 0; p < 12; p++) begin
      path.delete();
      g = $urandom_range(1, 4);
      for (int i = 0; i < g; i++) begin
        k.q = mk(rnd_comp(), rnd_comp(), rnd_comp(), rnd_comp());
        k.last = (i == g - 1);
        path.push_back(k);
      end
      run_path();
    end
    rand_bp = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
